// File: rtl/alu_op_sequencer.sv
// Purpose : one-at-a-time command sequencer that drives the 4-bit ALU and returns its result.
// Latency : result captured SETTLE_CYCLES edges after command accept, then held until taken.
// Backpr. : cmd_ready only in IDLE; rsp_valid/rsp_f/rsp_op hold stable until rsp_ready.
//
// Ports: clk/rst_n (async active-low); cmd_valid/cmd_ready/cmd_a/cmd_b/cmd_op command port;
//        alu_a/alu_b/alu_m registered ALU inputs, alu_f ALU result;
//        rsp_valid/rsp_ready/rsp_f/rsp_op response port; busy, op_count, mismatch status.
// Option : define ALU_SEQ_SELFCHECK_EN to build the golden-model result checker
//          (otherwise mismatch is tied to 0).
module alu_op_sequencer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [2:0] cmd_op,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_m,
  input  logic [7:0] alu_f,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_f,
  output logic [2:0] rsp_op,
  output logic       busy,
  output logic [7:0] op_count,
  output logic       mismatch
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] settle_cnt;
  logic       accept;
  logic       capture;
  logic       done;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake decode
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept    = 1'b1;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == 4'd0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        // A command presented here is not taken; it waits for the IDLE cycle.
        if (rsp_ready) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);

  // Datapath: ALU input latches, settle counter, response capture, op counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= 4'd0;
      alu_b      <= 4'd0;
      alu_m      <= 3'd0;
      settle_cnt <= 4'd0;
      rsp_f      <= 8'd0;
      rsp_op     <= 3'd0;
      op_count   <= 8'd0;
    end else begin
      if (accept) begin
        alu_a      <= cmd_a;
        alu_b      <= cmd_b;
        alu_m      <= cmd_op;
        settle_cnt <= 4'(SETTLE_CYCLES - 1);
      end else if (state == SETTLE && settle_cnt != 4'd0) begin
        settle_cnt <= settle_cnt - 4'd1;
      end
      if (capture) begin
        rsp_f  <= alu_f;
        rsp_op <= alu_m;
      end
      if (done) begin
        op_count <= op_count + 8'd1;
      end
    end
  end

`ifdef ALU_SEQ_SELFCHECK_EN
  // Reference result for the latched operands; widths follow the ALU opcode table.
  function automatic logic [7:0] golden(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] m);
    logic [4:0] a5, b5;
    a5 = {1'b0, a};
    b5 = {1'b0, b};
    case (m)
      3'd0:    golden = {3'b000, a5 + b5};
      3'd1:    golden = {3'b000, a5 - b5};
      3'd2:    golden = {3'b000, a5 + 5'd1};
      3'd3:    golden = {4'h0, a - 4'd1};
      3'd4:    golden = {3'b000, a, 1'b0};
      3'd5:    golden = {5'b00000, a[3:1]};
      3'd6:    golden = {4'h0, a & b};
      default: golden = {4'h0, a | b};
    endcase
  endfunction

  // Sticky until reset: one bad result is enough to flag the datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch <= 1'b0;
    end else if (capture && (alu_f != golden(alu_a, alu_b, alu_m))) begin
      mismatch <= 1'b1;
    end
  end
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [2:0] cmd_op;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_m;
  logic [7:0] alu_f;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_f;
  logic [2:0] rsp_op;
  logic       busy;
  logic [7:0] op_count;
  logic       mismatch;

  logic       alu_stuck;
  int         checks;
  int         failures;

`ifdef ALU_SEQ_SELFCHECK_EN
  localparam logic EXP_MM = 1'b1;
`else
  localparam logic EXP_MM = 1'b0;
`endif

  alu_op_sequencer #(.SETTLE_CYCLES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_op    (cmd_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_m     (alu_m),
    .alu_f     (alu_f),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_f     (rsp_f),
    .rsp_op    (rsp_op),
    .busy      (busy),
    .op_count  (op_count),
    .mismatch  (mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU, written with integer arithmetic and masks.
  always_comb begin
    int ia, ib, r;
    ia = int'(alu_a);
    ib = int'(alu_b);
    case (alu_m)
      3'd0:    r = (ia + ib) & 31;
      3'd1:    r = (ia - ib) & 31;
      3'd2:    r = (ia + 1) & 31;
      3'd3:    r = (ia - 1) & 15;
      3'd4:    r = ia * 2;
      3'd5:    r = ia / 2;
      3'd6:    r = ia & ib;
      default: r = ia | ib;
    endcase
    alu_f = alu_stuck ? 8'h00 : r[7:0];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_alu_a"},     32'(alu_a),     32'd0);
    chk({tag, "_alu_b"},     32'(alu_b),     32'd0);
    chk({tag, "_alu_m"},     32'(alu_m),     32'd0);
    chk({tag, "_rsp_f"},     32'(rsp_f),     32'd0);
    chk({tag, "_rsp_op"},    32'(rsp_op),    32'd0);
    chk({tag, "_op_count"},  32'(op_count),  32'd0);
    chk({tag, "_mismatch"},  32'(mismatch),  32'd0);
  endtask

  // Present a command (called just after an edge); returns after the accept edge.
  task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Count edges after the accept until rsp_valid rises (bounded).
  task automatic wait_rsp(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!rsp_valid && n < 20);
  endtask

  // Full operation with rsp_ready=1 and checks on latency and result.
  task automatic do_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] op, input logic [7:0] exp);
    int n;
    issue(a, b, op);
    chk({tag, "_alu_a"}, 32'(alu_a), 32'(a));
    chk({tag, "_alu_m"}, 32'(alu_m), 32'(op));
    wait_rsp(n);
    chk({tag, "_lat"},    32'(n),      32'd2);
    chk({tag, "_rsp_f"},  32'(rsp_f),  32'(exp));
    chk({tag, "_rsp_op"}, 32'(rsp_op), 32'(op));
    @(posedge clk); #1;
    chk({tag, "_vld_1cyc"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rdy_back"}, 32'(cmd_ready), 32'd1);
  endtask

  // Operation without per-step result checks, used to run the counter around.
  task automatic quick_op(input logic [3:0] a);
    int n;
    issue(a, 4'd1, 3'd0);
    wait_rsp(n);
    if (n >= 20) chk("quick_timeout", 32'(n), 32'd2);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    bit saw_vld;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_a     = 4'd0;
    cmd_b     = 4'd0;
    cmd_op    = 3'd0;
    rsp_ready = 1'b1;
    alu_stuck = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic opcode table
    do_op("add",  4'h9, 4'h8, 3'd0, 8'h11);
    do_op("sub",  4'h3, 4'h5, 3'd1, 8'h1E);
    do_op("inc",  4'hF, 4'h0, 3'd2, 8'h10);
    do_op("dec",  4'h0, 4'h0, 3'd3, 8'h0F);
    do_op("mul2", 4'hB, 4'h0, 3'd4, 8'h16);
    do_op("div2", 4'h7, 4'h0, 3'd5, 8'h03);
    do_op("and",  4'hC, 4'hA, 3'd6, 8'h08);
    do_op("or",   4'hC, 4'hA, 3'd7, 8'h0E);
    chk("count8", 32'(op_count), 32'd8);
    chk("mm_clean", 32'(mismatch), 32'd0);

    // Backpressure with a pending command during RESP
    rsp_ready = 1'b0;
    issue(4'h2, 4'h3, 3'd0);
    wait_rsp(n);
    chk("bp_lat", 32'(n), 32'd2);
    cmd_a = 4'h6; cmd_b = 4'h4; cmd_op = 3'd1; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_vld",    32'(rsp_valid), 32'd1);
      chk("bp_f",      32'(rsp_f),     32'h05);
      chk("bp_op",     32'(rsp_op),    32'd0);
      chk("bp_cmdrdy", 32'(cmd_ready), 32'd0);
      chk("bp_alu_a",  32'(alu_a),     32'h2);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_hs_vld",   32'(rsp_valid), 32'd0);
    chk("bp_hs_rdy",   32'(cmd_ready), 32'd1);
    chk("bp_noaccept", 32'(alu_a),     32'h2);
    chk("bp_count",    32'(op_count),  32'd9);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("bp_accept_a", 32'(alu_a), 32'h6);
    chk("bp_accept_m", 32'(alu_m), 32'd1);
    chk("bp_busy",     32'(busy),  32'd1);
    wait_rsp(n);
    chk("bp2_lat", 32'(n),     32'd2);
    chk("bp2_f",   32'(rsp_f), 32'h02);
    @(posedge clk); #1;
    chk("bp_count2", 32'(op_count), 32'd10);

    // Reset in the middle of SETTLE
    issue(4'h5, 4'h5, 3'd7);
    chk("mid_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    saw_vld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) saw_vld = 1'b1;
    end
    chk("midrst_novld", 32'(saw_vld),   32'd0);
    chk("midrst_rdy",   32'(cmd_ready), 32'd1);

    // Counter wrap
    for (int i = 0; i < 255; i++) quick_op(4'(i));
    chk("count255", 32'(op_count), 32'd255);
    quick_op(4'h3);
    chk("count_wrap", 32'(op_count), 32'd0);

    // Self-check: faulty ALU result, then correct results
    alu_stuck = 1'b1;
    do_op("stuck_add", 4'h1, 4'h1, 3'd0, 8'h00);
    chk("mm_set", 32'(mismatch), 32'(EXP_MM));
    alu_stuck = 1'b0;
    do_op("after_add", 4'h1, 4'h1, 3'd0, 8'h02);
    do_op("after_or",  4'h3, 4'h4, 3'd7, 8'h07);
    chk("mm_sticky", 32'(mismatch), 32'(EXP_MM));
    rst_n = 1'b0;
    #1;
    chk("mm_rst", 32'(mismatch), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
